// File: rtl/display_scheduler_if.sv
// -----------------------------------------------------------------------------
// display_scheduler_if
//   Bundles the requester-facing and driver-facing signals of the character
//   display scheduler.
//   Requester side : req (level), ascii_in (packed strings), ack (pulse),
//                    grant_id, busy
//   Driver side    : COMMAND (one-cycle write strobe), ASCII (held string)
//   modport master : the requesters / display driver environment
//   modport slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface display_scheduler_if #(
  parameter int SIZE = 4,
  parameter int NREQ = 3
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req;
  logic [NREQ*SIZE*8-1:0] ascii_in;
  logic [NREQ-1:0]        ack;
  logic [IW-1:0]          grant_id;
  logic                   busy;
  logic                   COMMAND;
  logic [SIZE*8-1:0]      ASCII;

  modport master (
    output req, ascii_in,
    input  ack, grant_id, busy, COMMAND, ASCII
  );

  modport slave (
    input  req, ascii_in,
    output ack, grant_id, busy, COMMAND, ASCII
  );
endinterface

// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//   Shares one character display driver among NREQ requesters. Requests are
//   granted one at a time in round-robin order; the winner's string is
//   snapshotted into ASCII, COMMAND strobes for one cycle, ASCII is held for
//   SLOT_CYCLES cycles, and the winner gets a one-cycle ack. With no traffic
//   for long enough, the last string is replayed to refresh the display.
//
//   Ports
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : display_scheduler_if.slave
//              req / ascii_in in, ack / grant_id / busy / COMMAND / ASCII out
//
//   Slot timeline (grant decided at edge n):
//     cycle n+1            ISSUE  COMMAND=1, busy=1
//     cycles n+2..n+S      HOLD   busy=1
//     cycle n+S+1          DONE   ack pulse (not for refresh), busy=0
//     cycle n+S+2          IDLE   next arbitration
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int SIZE           = 4,
  parameter int NREQ           = 3,
  parameter int SLOT_CYCLES    = 64,
  parameter int REFRESH_CYCLES = 4096
) (
  input logic          clk,
  input logic          rst_n,
  display_scheduler_if.slave bus
);

  localparam int W  = SIZE * 8;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [SW-1:0] SLOT_LAST    = SW'(SLOT_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam bit            REFRESH_EN   = (REFRESH_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [SW-1:0]   slot_cnt;
  logic [RW-1:0]   refresh_cnt;
  logic            refresh_due;
  logic            refresh_slot;

  // Arbitration results
  logic [NREQ-1:0] rot;
  logic            found;
  int              win_idx;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   next_ptr;
  logic [W-1:0]    winner_ascii;
  logic [NREQ-1:0] ack_onehot;

  // Round-robin: rotate req so that bit 0 is the requester at ptr, take the
  // first set bit, then map back to an absolute index.
  // NOTE: every signal gets a default at the top of the always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    rot          = NREQ'({bus.req, bus.req} >> ptr);
    found        = 1'b0;
    win_idx      = 0;
    winner_ascii = bus.ascii_in[W-1:0];
    ack_onehot   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found   = 1'b1;
        win_idx = int'(ptr) + k;
      end
    end
    if (win_idx >= NREQ) win_idx = win_idx - NREQ;
    winner   = IW'(win_idx);
    next_ptr = (win_idx + 1 >= NREQ) ? '0 : IW'(win_idx + 1);
    for (int i = 0; i < NREQ; i++) begin
      if (i == win_idx) winner_ascii = bus.ascii_in[i*W +: W];
      ack_onehot[i] = (i == int'(bus.grant_id));
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      slot_cnt     <= '0;
      refresh_cnt  <= '0;
      refresh_due  <= 1'b0;
      refresh_slot <= 1'b0;
      bus.ack      <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.COMMAND  <= 1'b0;
      bus.ASCII    <= {SIZE{8'h20}};
    end else begin
      // Pulses fall back to zero unless a state below re-asserts them.
      bus.ack     <= '0;
      bus.COMMAND <= 1'b0;

      // Refresh counting only runs through quiet IDLE cycles.
      if (state != IDLE) begin
        refresh_cnt <= '0;
        refresh_due <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (found) begin
            // A request always beats a pending refresh.
            state        <= ISSUE;
            bus.COMMAND  <= 1'b1;
            bus.busy     <= 1'b1;
            bus.ASCII    <= winner_ascii;
            bus.grant_id <= winner;
            ptr          <= next_ptr;
            slot_cnt     <= SW'(1);
            refresh_slot <= 1'b0;
            refresh_cnt  <= '0;
            refresh_due  <= 1'b0;
          end else if (REFRESH_EN && refresh_due) begin
            // Replay: ASCII, grant_id and ptr are left untouched.
            state        <= ISSUE;
            bus.COMMAND  <= 1'b1;
            bus.busy     <= 1'b1;
            slot_cnt     <= SW'(1);
            refresh_slot <= 1'b1;
            refresh_cnt  <= '0;
            refresh_due  <= 1'b0;
          end else if (REFRESH_EN) begin
            // Terminal count arms the replay; it fires from the next IDLE edge.
            if (refresh_cnt == REFRESH_LAST) refresh_due <= 1'b1;
            else                             refresh_cnt <= refresh_cnt + 1'b1;
          end
        end

        ISSUE: state <= HOLD;

        HOLD: begin
          if (slot_cnt == SLOT_LAST) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            if (!refresh_slot) bus.ack <= ack_onehot;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

  localparam logic [31:0] S_TIME = 32'h54494D45;  // "TIME"
  localparam logic [31:0] S_CLK  = 32'h31323A33;  // "12:3"
  localparam logic [31:0] S_MENU = 32'h4D454E55;  // "MENU"
  localparam logic [31:0] S_ALRM = 32'h414C524D;  // "ALRM"
  localparam logic [31:0] SPACES = 32'h20202020;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Round-robin stimulus table: request vector applied, expected winner,
  // expected cycles from request to COMMAND.
  logic [2:0]  rr_req [8] = '{3'b111, 3'b110, 3'b100, 3'b101, 3'b100, 3'b101, 3'b101, 3'b101};
  int          rr_gid [8] = '{0, 1, 2, 0, 2, 0, 2, 0};
  int          rr_lat [8] = '{1, 2, 2, 2, 2, 2, 2, 2};
  logic [31:0] str_of [3] = '{S_TIME, S_CLK, S_MENU};

  display_scheduler_if #(.SIZE(4), .NREQ(3)) ifa ();
  display_scheduler_if #(.SIZE(4), .NREQ(3)) ifb ();

  display_scheduler #(.SIZE(4), .NREQ(3), .SLOT_CYCLES(64), .REFRESH_CYCLES(4096)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  display_scheduler #(.SIZE(4), .NREQ(3), .SLOT_CYCLES(64), .REFRESH_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifa.req = '0;
    ifb.req = '0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
  endtask

  // Drives req on dut_a, waits for the grant, then follows the slot to its
  // ack. Returns observations only; callers do the comparisons.
  task automatic run_slot(input logic [2:0] r, output int lat, output logic [1:0] gid,
                          output logic [31:0] asc, output int len,
                          output logic [2:0] ack_v, output logic ok);
    ifa.req = r;
    lat = 0;
    do begin tick(); lat++; end while (ifa.COMMAND !== 1'b1 && lat < 10);
    gid = ifa.grant_id;
    asc = ifa.ASCII;
    ok  = (ifa.busy === 1'b1);
    len = 0;
    do begin
      tick();
      len++;
      if (ifa.ASCII !== asc || ifa.grant_id !== gid || ifa.COMMAND !== 1'b0) ok = 1'b0;
      if (ifa.ack === 3'b000 && ifa.busy !== 1'b1) ok = 1'b0;
    end while (ifa.ack === 3'b000 && len < 200);
    ack_v = ifa.ack;
    if (ifa.busy !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({ifa.COMMAND, ifa.busy, ifa.ack, ifa.grant_id} !== 7'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b, expected 0000000", {ifa.COMMAND, ifa.busy, ifa.ack, ifa.grant_id}); end
    checks++; if (ifa.ASCII !== SPACES) begin errors++;
      $display("FAIL reset_ascii: got %h, expected %h", ifa.ASCII, SPACES); end
    tick();
    tick();
    rst_n = 1'b1;
    // Start a write, then pull reset in the middle of HOLD.
    ifa.req = 3'b100;
    tick();
    repeat (10) tick();
    checks++; if (ifa.busy !== 1'b1 || ifa.grant_id !== 2'd2) begin errors++;
      $display("FAIL reset_pre_busy: got busy=%b id=%0d, expected busy=1 id=2", ifa.busy, ifa.grant_id); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ifa.COMMAND, ifa.busy, ifa.ack, ifa.grant_id} !== 7'b0) begin errors++;
      $display("FAIL reset_mid_ctrl: got %b, expected 0000000", {ifa.COMMAND, ifa.busy, ifa.ack, ifa.grant_id}); end
    checks++; if (ifa.ASCII !== SPACES) begin errors++;
      $display("FAIL reset_mid_ascii: got %h, expected %h", ifa.ASCII, SPACES); end
    ifa.req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (ifa.ack !== 3'b000 || ifa.COMMAND !== 1'b0 || ifa.busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++;
      $display("FAIL reset_no_ack: got activity=%b, expected 0", seen); end
  endtask

  task automatic test_single_write();
    int lat, len; logic [1:0] gid; logic [31:0] asc; logic [2:0] ack_v; logic ok;
    run_slot(3'b010, lat, gid, asc, len, ack_v, ok);
    checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d, expected 1", lat); end
    checks++; if (gid !== 2'd1) begin errors++; $display("FAIL single_grant_id: got %0d, expected 1", gid); end
    checks++; if (asc !== S_CLK) begin errors++; $display("FAIL single_ascii: got %h, expected %h", asc, S_CLK); end
    checks++; if (len !== 64) begin errors++; $display("FAIL single_slot_len: got %0d, expected 64", len); end
    checks++; if (ack_v !== 3'b010) begin errors++; $display("FAIL single_ack: got %b, expected 010", ack_v); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_hold: got stable=%b, expected 1", ok); end
    ifa.req = '0;
    tick();
    checks++; if (ifa.ack !== 3'b000) begin errors++; $display("FAIL single_ack_pulse: got %b, expected 000", ifa.ack); end
    tick();
  endtask

  task automatic test_round_robin();
    int lat, len; logic [1:0] gid; logic [31:0] asc; logic [2:0] ack_v, exp_ack; logic ok;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_slot(rr_req[i], lat, gid, asc, len, ack_v, ok);
      exp_ack = 3'b001 << rr_gid[i];
      checks++; if (int'(gid) !== rr_gid[i]) begin errors++;
        $display("FAIL rr_grant[%0d]: got %0d, expected %0d", i, gid, rr_gid[i]); end
      checks++; if (lat !== rr_lat[i]) begin errors++;
        $display("FAIL rr_latency[%0d]: got %0d, expected %0d", i, lat, rr_lat[i]); end
      checks++; if (asc !== str_of[rr_gid[i]] || ack_v !== exp_ack) begin errors++;
        $display("FAIL rr_data[%0d]: got ascii=%h ack=%b, expected ascii=%h ack=%b",
                 i, asc, ack_v, str_of[rr_gid[i]], exp_ack); end
      checks++; if (len !== 64 || ok !== 1'b1) begin errors++;
        $display("FAIL rr_slot[%0d]: got len=%0d stable=%b, expected len=64 stable=1", i, len, ok); end
    end
    ifa.req = '0;
    tick();
    tick();
  endtask

  task automatic test_snapshot();
    int n, lat, len; logic [1:0] gid; logic [31:0] asc; logic [2:0] ack_v; logic ok, stable;
    ifa.req = 3'b001;
    tick();
    checks++; if (ifa.COMMAND !== 1'b1 || ifa.ASCII !== S_TIME) begin errors++;
      $display("FAIL snap_grant: got cmd=%b ascii=%h, expected cmd=1 ascii=%h", ifa.COMMAND, ifa.ASCII, S_TIME); end
    ifa.ascii_in[31:0] = S_ALRM;
    stable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (ifa.ASCII !== S_TIME) stable = 1'b0;
    end while (ifa.ack === 3'b000 && n < 200);
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL snap_hold: got stable=%b, expected 1", stable); end
    checks++; if (ifa.ack !== 3'b001) begin errors++; $display("FAIL snap_ack: got %b, expected 001", ifa.ack); end
    run_slot(3'b001, lat, gid, asc, len, ack_v, ok);
    checks++; if (asc !== S_ALRM || gid !== 2'd0) begin errors++;
      $display("FAIL snap_next: got ascii=%h id=%0d, expected ascii=%h id=0", asc, gid, S_ALRM); end
    ifa.req = '0;
    ifa.ascii_in[31:0] = S_TIME;
    tick();
    tick();
  endtask

  task automatic test_drop_mid_slot();
    int n;
    ifa.req = 3'b100;
    tick();
    checks++; if (ifa.COMMAND !== 1'b1 || ifa.grant_id !== 2'd2) begin errors++;
      $display("FAIL drop_grant: got cmd=%b id=%0d, expected cmd=1 id=2", ifa.COMMAND, ifa.grant_id); end
    n = 0;
    do begin
      tick();
      n++;
      if (n == 10) ifa.req = '0;
    end while (ifa.ack === 3'b000 && n < 200);
    checks++; if (n !== 64) begin errors++; $display("FAIL drop_slot_len: got %0d, expected 64", n); end
    checks++; if (ifa.ack !== 3'b100) begin errors++; $display("FAIL drop_ack: got %b, expected 100", ifa.ack); end
    tick();
    tick();
    checks++; if (ifa.COMMAND !== 1'b0 || ifa.busy !== 1'b0) begin errors++;
      $display("FAIL drop_idle: got cmd=%b busy=%b, expected 0 0", ifa.COMMAND, ifa.busy); end
  endtask

  task automatic test_refresh();
    int t; logic ack_seen;
    do_reset();
    ifb.req = 3'b010;
    tick();
    checks++; if (ifb.COMMAND !== 1'b1 || ifb.grant_id !== 2'd1) begin errors++;
      $display("FAIL ref_write: got cmd=%b id=%0d, expected cmd=1 id=1", ifb.COMMAND, ifb.grant_id); end
    t = 0;
    do begin tick(); t++; end while (ifb.ack === 3'b000 && t < 200);
    checks++; if (ifb.ack !== 3'b010) begin errors++; $display("FAIL ref_write_ack: got %b, expected 010", ifb.ack); end
    ifb.req = '0;
    // DONE cycle -> 17 quiet IDLE cycles -> refresh ISSUE.
    ack_seen = 1'b0;
    t = 0;
    do begin tick(); t++; if (ifb.ack !== 3'b000) ack_seen = 1'b1; end while (ifb.COMMAND !== 1'b1 && t < 300);
    checks++; if (t !== 18) begin errors++; $display("FAIL ref_first: got %0d cycles, expected 18", t); end
    checks++; if (ifb.ASCII !== S_CLK || ifb.grant_id !== 2'd1) begin errors++;
      $display("FAIL ref_content: got ascii=%h id=%0d, expected ascii=%h id=1", ifb.ASCII, ifb.grant_id, S_CLK); end
    for (int p = 0; p < 2; p++) begin
      t = 0;
      do begin tick(); t++; if (ifb.ack !== 3'b000) ack_seen = 1'b1; end while (ifb.COMMAND !== 1'b1 && t < 300);
      checks++; if (t !== 82) begin errors++; $display("FAIL ref_period[%0d]: got %0d cycles, expected 82", p, t); end
    end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL ref_no_ack: got ack seen=%b, expected 0", ack_seen); end
    // Land a request exactly on the cycle the next refresh would fire.
    repeat (81) tick();
    checks++; if (ifb.busy !== 1'b0 || ifb.COMMAND !== 1'b0) begin errors++;
      $display("FAIL ref_fire_idle: got busy=%b cmd=%b, expected 0 0", ifb.busy, ifb.COMMAND); end
    ifb.req = 3'b001;
    tick();
    checks++; if (ifb.COMMAND !== 1'b1 || ifb.grant_id !== 2'd0 || ifb.ASCII !== S_TIME) begin errors++;
      $display("FAIL ref_collide_grant: got cmd=%b id=%0d ascii=%h, expected cmd=1 id=0 ascii=%h",
               ifb.COMMAND, ifb.grant_id, ifb.ASCII, S_TIME); end
    t = 0;
    do begin tick(); t++; end while (ifb.ack === 3'b000 && t < 200);
    checks++; if (t !== 64 || ifb.ack !== 3'b001) begin errors++;
      $display("FAIL ref_collide_ack: got len=%0d ack=%b, expected len=64 ack=001", t, ifb.ack); end
    ifb.req = '0;
    t = 0;
    do begin tick(); t++; end while (ifb.COMMAND !== 1'b1 && t < 300);
    checks++; if (t !== 18 || ifb.ASCII !== S_TIME || ifb.grant_id !== 2'd0) begin errors++;
      $display("FAIL ref_after_collide: got %0d cycles ascii=%h id=%0d, expected 18 cycles ascii=%h id=0",
               t, ifb.ASCII, ifb.grant_id, S_TIME); end
  endtask

  initial begin
    ifa.req      = '0;
    ifb.req      = '0;
    ifa.ascii_in = {S_MENU, S_CLK, S_TIME};
    ifb.ascii_in = {S_MENU, S_CLK, S_TIME};
    test_reset();
    test_single_write();
    test_round_robin();
    test_snapshot();
    test_drop_mid_slot();
    test_refresh();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
